// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizing for the register-file arbiter.
package regfile_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_AW      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Winner selection: first set request at or after ptr_i, wrapping around.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  k;
  logic [IW:0]    sum;
  logic           found;

  // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N-1:0];

  always_comb begin
    found   = 1'b0;
    k       = '0;
    sum     = '0;
    idx_o   = '0;
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = IW'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, k};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o = sum[IW-1:0];
    for (int i = 0; i < N; i++) begin
      grant_o[i] = found && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Multi-requester front end to a single-port register file, one transaction at a time.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic                     rf_wr_en,
  output logic [AW-1:0]            rf_addr,
  output logic [WIDTH-1:0]         rf_wr_data,
  input  logic [WIDTH-1:0]         rf_rd_data
);

  state_e             state_q;
  logic               wr_q, err_q;
  logic               rsp_valid_q, rsp_err_q, rf_wr_en_q;
  logic [IW-1:0]      rsp_id_q;
  logic [WIDTH-1:0]   rsp_rdata_q, rf_wr_data_q;
  logic [AW-1:0]      rf_addr_q;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win_idx, ptr;
  logic [AW-1:0]      addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic               any_req, sel_write, sel_err;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_wdata;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*WIDTH +: WIDTH];
  end

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

`ifdef REGFILE_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      ptr_q <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  assign any_req   = |req_valid;
  assign sel_write = req_write[win_idx];
  assign sel_addr  = addr_arr[win_idx];
  assign sel_wdata = wdata_arr[win_idx];
  assign sel_err   = 32'(sel_addr) >= 32'(DEPTH);

  // Gated by rst so no command can be accepted while reset is held.
  assign req_ready = (rst && state_q == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_rdata_q  <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            wr_q         <= sel_write;
            err_q        <= sel_err;
            rsp_id_q     <= win_idx;
            rf_addr_q    <= sel_addr;
            rf_wr_data_q <= sel_wdata;
            rf_wr_en_q   <= sel_write & ~sel_err;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rf_wr_en_q  <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (wr_q || err_q) ? '0 : rf_rd_data;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file attached.
module tb_regfile_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int D  = 12;
  localparam int A  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_write, req_ready;
  logic [NR*A-1:0] req_addr;
  logic [NR*W-1:0] req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_rdata;
  logic            rf_wr_en;
  logic [A-1:0]    rf_addr;
  logic [W-1:0]    rf_wr_data, rf_rd_data;

  logic [W-1:0]    mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rf_wr_en   (rf_wr_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .rf_rd_data (rf_rd_data)
  );

  assign rf_rd_data = mem[rf_addr];
  always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int id, input logic wr, input logic [3:0] addr, input logic [7:0] wd);
    req_write[id]          = wr;
    req_addr[id*A +: A]    = addr;
    req_wdata[id*W +: W]   = wd;
  endtask

  // Full transaction with rsp_ready high; call while the arbiter is idle, shortly after a negedge.
  task automatic txn(input int id, input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input logic exp_err);
    logic [3:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    set_cmd(id, wr, addr, wd);
    req_valid = oh;
    #1 chk("accept_ready", req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_wr_en", rf_wr_en, wr && !exp_err);
    if (!exp_err) begin
      chk("exec_addr", rf_addr, addr);
      if (wr) chk("exec_wdata", rf_wr_data, wd);
    end
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, id);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_wr_en", rf_wr_en, 0);
    @(negedge clk);
    #1 chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    logic [3:0] exp_oh;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst       = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wr_data", rf_wr_data, 0);
    req_valid = 4'b0101;
    #1 chk("rst_ready_gated", req_ready, 0);
    @(negedge clk);
    chk("rst_hold_valid", rsp_valid, 0);
    chk("rst_hold_wr_en", rf_wr_en, 0);
    req_valid = '0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    #1;

    // Single write, read-back, out-of-range write and read.
    txn(0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0);
    chk("mem3_written", mem[3], 8'hA5);
    txn(2, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);
    txn(1, 1'b1, 4'd14, 8'h3C, 8'h00, 1'b1);
    chk("mem14_untouched", mem[14], 8'h00);
    txn(3, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1);

    // Contention: all four valid, reads of address = requester index.
    for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, 4'(i), 8'h00);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_oh = '0;
`ifdef REGFILE_ARB_RR_EN
      exp_oh[k % 4] = 1'b1;
`else
      exp_oh[0] = 1'b1;
`endif
      #1 chk("cont_grant", req_ready, exp_oh);
      @(negedge clk);
      @(negedge clk);
      #1 chk("cont_rsp_id", rsp_id, (exp_oh == 4'b0001) ? 0 : (exp_oh == 4'b0010) ? 1 :
                                     (exp_oh == 4'b0100) ? 2 : 3);
      @(negedge clk);
    end
    req_valid = '0;

    // Backpressure: response held for 5 cycles while requester 0 waits.
    rsp_ready = 1'b0;
    set_cmd(1, 1'b1, 4'd5, 8'h5A);
    req_valid = 4'b0010;
    #1 chk("bp_accept", req_ready, 4'b0010);
    @(negedge clk);
    set_cmd(0, 1'b0, 4'd3, 8'h00);
    req_valid = 4'b0001;
    #1 chk("bp_exec_ready", req_ready, 0);
    @(negedge clk);
    #1 chk("bp_resp_valid", rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_hold_err", rsp_err, 0);
      chk("bp_hold_rdata", rsp_rdata, 0);
      chk("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0001);
    chk("bp_mem5", mem[5], 8'h5A);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_rd_id", rsp_id, 0);
    chk("bp_rd_data", rsp_rdata, 8'hA5);
    @(negedge clk);
    #1;

    // Reset asserted in the middle of a write EXEC.
    set_cmd(2, 1'b1, 4'd7, 8'h77);
    req_valid = 4'b0100;
    #1 chk("rx_accept", req_ready, 4'b0100);
    @(negedge clk);
    #1 chk("rx_exec_wr_en", rf_wr_en, 1);
    rst = 1'b0;
    #1;
    chk("rx_wr_en_off", rf_wr_en, 0);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_req_ready", req_ready, 0);
    chk("rx_rf_addr", rf_addr, 0);
    @(negedge clk);
    #1;
    chk("rx_no_resp", rsp_valid, 0);
    chk("rx_mem7", mem[7], 8'h00);
    rst = 1'b1;
    set_cmd(1, 1'b0, 4'd5, 8'h00);
    set_cmd(3, 1'b0, 4'd5, 8'h00);
    req_valid = 4'b1010;
    #1 chk("rx_ptr_zero_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 chk("rx_after_id", rsp_id, 1);
    chk("rx_after_rdata", rsp_rdata, 8'h5A);
    @(negedge clk);
    #1 chk("rx_after_idle", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
